// File: rtl/aes_key_pkg.sv
// Shared types and constants for the AES-256 key-schedule controller.
// Widths are fixed by AES-256: 256-bit cipher key, fifteen 128-bit round keys.
package aes_key_pkg;

    typedef logic [0:255] key256_t;
    typedef logic [0:127] word128_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } ks_state_e;

    localparam int NUM_ROUND_KEYS = 15;
    localparam int NUM_ITERS      = 7;

    // Iteration n produces round keys 2n and 2n+1.
    function automatic logic [3:0] word_base(input logic [2:0] iter);
        return {iter, 1'b0};
    endfunction

endpackage

// File: rtl/aes256_key_sched_ctrl_buf.sv
// Round-key buffer: 15 x 128-bit registers with a paired lower/upper write
// and a combinational read port; out-of-range indices read as zero.
module round_key_buf
    import aes_key_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       wr_lo_en,
    input  logic       wr_hi_en,
    input  logic [3:0] wr_base_idx,
    input  word128_t   wr_lo_data,
    input  word128_t   wr_hi_data,
    input  logic [3:0] rd_idx,
    output word128_t   rd_data
);

    word128_t word_q [NUM_ROUND_KEYS];

    genvar gi;
    for (gi = 0; gi < NUM_ROUND_KEYS; gi++) begin : gen_entry
        word128_t entry_reg;

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                entry_reg <= '0;
            end else if (wr_lo_en && (wr_base_idx == 4'(gi))) begin
                entry_reg <= wr_lo_data;
            end else if (wr_hi_en && ((wr_base_idx + 4'd1) == 4'(gi))) begin
                entry_reg <= wr_hi_data;
            end
        end

        assign word_q[gi] = entry_reg;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_ROUND_KEYS; i++) begin
            if (rd_idx == 4'(i)) begin
                rd_data = word_q[i];
            end
        end
    end

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key-schedule sequencer: loads a cipher key, drives the external
// round_key datapath through iterations 1..7 and collects 15 round keys.
module aes256_key_sched_ctrl
    import aes_key_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       flush_i,
    input  logic       v_i,
    output logic       ready_o,
    input  key256_t    key_i,
    output logic       rk_v_o,
    input  logic       rk_ready_i,
    output key256_t    rk_k_o,
    output logic [0:3] rk_r_o,
    input  logic       rk_v_i,
    output logic       rk_yumi_o,
    input  key256_t    rk_result_i,
    input  logic [3:0] rd_idx_i,
    output word128_t   rd_key_o,
    output logic       keys_valid_o,
    output logic       done_o
);

    ks_state_e  state_reg, state_next;
    logic [3:0] iter_reg, iter_next;
    key256_t    cur_reg, cur_next;
    logic       done_reg, done_next;

    logic       wr_lo_en, wr_hi_en;
    logic [3:0] wr_base_idx;
    word128_t   wr_lo_data, wr_hi_data;
    logic       last_iter;

    assign last_iter = (iter_reg == 4'(NUM_ITERS));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
            iter_reg  <= 4'd1;
            cur_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            iter_reg  <= iter_next;
            cur_reg   <= cur_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        iter_next    = iter_reg;
        cur_next     = cur_reg;
        done_next    = 1'b0;
        wr_lo_en     = 1'b0;
        wr_hi_en     = 1'b0;
        wr_base_idx  = 4'd0;
        wr_lo_data   = key_i[0:127];
        wr_hi_data   = key_i[128:255];
        ready_o      = 1'b0;
        rk_v_o       = 1'b0;
        rk_yumi_o    = rk_v_i;   // stray results outside ISSUE are drained
        keys_valid_o = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                ready_o      = 1'b1;
                keys_valid_o = (state_reg == DONE);
                if (v_i) begin
                    wr_lo_en   = 1'b1;
                    wr_hi_en   = 1'b1;
                    cur_next   = key_i;
                    iter_next  = 4'd1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                rk_v_o    = 1'b1;
                rk_yumi_o = 1'b0;
                if (rk_ready_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (rk_v_i) begin
                    wr_lo_en    = 1'b1;
                    wr_hi_en    = !last_iter;   // upper half of iteration 7 is unused
                    wr_base_idx = word_base(iter_reg[2:0]);
                    wr_lo_data  = rk_result_i[0:127];
                    wr_hi_data  = rk_result_i[128:255];
                    if (last_iter) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        cur_next   = rk_result_i;
                        iter_next  = iter_reg + 4'd1;
                        state_next = ISSUE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (flush_i) begin
            state_next = IDLE;
            iter_next  = 4'd1;
            done_next  = 1'b0;
            wr_lo_en   = 1'b0;
            wr_hi_en   = 1'b0;
        end
    end

    assign rk_k_o = (state_reg == ISSUE) ? cur_reg : '0;
    assign rk_r_o = (state_reg == ISSUE) ? iter_reg : 4'd0;
    assign done_o = done_reg;

    round_key_buf u_buf (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .wr_lo_en    (wr_lo_en),
        .wr_hi_en    (wr_hi_en),
        .wr_base_idx (wr_base_idx),
        .wr_lo_data  (wr_lo_data),
        .wr_hi_data  (wr_hi_data),
        .rd_idx      (rd_idx_i),
        .rd_data     (rd_key_o)
    );

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Bench for aes256_key_sched_ctrl: emulates round_key with an AES-256 step,
// and checks requests and served round keys against a full key expansion.
module tb_aes256_key_sched_ctrl;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic         reset_i, flush_i, v_i, ready_o;
    logic [0:255] key_i, rk_k_o, rk_result_i;
    logic         rk_v_o, rk_ready_i, rk_v_i, rk_yumi_o;
    logic [0:3]   rk_r_o;
    logic [3:0]   rd_idx_i;
    logic [0:127] rd_key_o;
    logic         keys_valid_o, done_o;

    aes256_key_sched_ctrl dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .key_i        (key_i),
        .rk_v_o       (rk_v_o),
        .rk_ready_i   (rk_ready_i),
        .rk_k_o       (rk_k_o),
        .rk_r_o       (rk_r_o),
        .rk_v_i       (rk_v_i),
        .rk_yumi_o    (rk_yumi_o),
        .rk_result_i  (rk_result_i),
        .rd_idx_i     (rd_idx_i),
        .rd_key_o     (rd_key_o),
        .keys_valid_o (keys_valid_o),
        .done_o       (done_o)
    );

    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- AES helpers and reference model ----------------
    logic [7:0]   sbox [256];
    logic [31:0]  model_w [60];
    logic [127:0] pend_rk [15];
    logic [127:0] valid_rk [15];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Standard AES-256 expansion of the whole key into 60 words.
    task automatic model_expand(input logic [255:0] key);
        logic [31:0] t;
        for (int i = 0; i < 8; i++) model_w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = model_w[i-1];
            if (i % 8 == 0) t = sub_word(rot_word(t)) ^ {8'(1 << (i/8 - 1)), 24'h0};
            else if (i % 8 == 4) t = sub_word(t);
            model_w[i] = model_w[i-8] ^ t;
        end
        for (int j = 0; j < 15; j++)
            pend_rk[j] = {model_w[4*j], model_w[4*j+1], model_w[4*j+2], model_w[4*j+3]};
    endtask

    function automatic logic [255:0] model_chunk(input int r);
        logic [255:0] c;
        c = '0;
        if (r >= 1 && r <= 7)
            for (int i = 0; i < 8; i++) c[255-32*i -: 32] = model_w[8*(r-1)+i];
        return c;
    endfunction

    function automatic logic [127:0] exp_rd(input logic [3:0] idx);
        if (idx == 4'd15) return '0;
        return valid_rk[idx];
    endfunction

    // One round_key iteration: next eight words from the previous eight.
    function automatic logic [255:0] rk_step(input logic [255:0] k, input int r);
        logic [31:0]  w [16];
        logic [31:0]  t;
        logic [255:0] o;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        for (int i = 8; i < 16; i++) begin
            t = w[i-1];
            if (i == 8) t = sub_word(rot_word(t)) ^ {8'(1 << (r - 1)), 24'h0};
            else if (i == 12) t = sub_word(t);
            w[i] = w[i-8] ^ t;
        end
        o = '0;
        for (int i = 0; i < 8; i++) o[255-32*i -: 32] = w[8+i];
        return o;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
        return k;
    endfunction

    // ---------------- round_key responder ----------------
    int           resp_lat = 1;
    int           stall_n = 0;
    int           stall_cnt = 0;
    int           resp_cnt = 0;
    logic [255:0] resp_data = '0;

    initial begin
        logic req_hs, res_hs;
        rk_ready_i  = 1'b1;
        rk_v_i      = 1'b0;
        rk_result_i = '0;
        forever begin
            @(negedge clk_i);
            if (rk_v_o) begin
                rk_ready_i = (stall_cnt >= stall_n);
                if (stall_cnt < stall_n) stall_cnt++;
            end else begin
                rk_ready_i = (stall_n == 0);
                stall_cnt  = 0;
            end
            req_hs = rk_v_o && rk_ready_i;
            res_hs = rk_v_i && rk_yumi_o;
            if (req_hs) resp_data = rk_step(rk_k_o, int'(rk_r_o));
            @(posedge clk_i);
            #1;
            if (reset_i) begin
                rk_v_i   = 1'b0;
                resp_cnt = 0;
            end else begin
                if (res_hs) rk_v_i = 1'b0;
                if (req_hs) resp_cnt = resp_lat;
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        rk_v_i      = 1'b1;
                        rk_result_i = resp_data;
                    end
                end
            end
        end
    end

    // ---------------- read-index driver ----------------
    logic       rand_idx = 1'b0;
    logic [3:0] rand_val = 4'd0;
    logic [3:0] fixed_idx = 4'd0;
    assign rd_idx_i = rand_idx ? rand_val : fixed_idx;

    initial forever begin
        @(posedge clk_i);
        #2;
        rand_val = 4'($urandom_range(0, 15));
    end

    // ---------------- per-cycle compare against the model ----------------
    int         exp_r = 1;
    logic [3:0] r_seq [$];

    initial begin
        logic         prev_stall;
        logic [255:0] prev_k;
        logic [3:0]   prev_r;
        prev_stall = 1'b0;
        prev_k     = '0;
        prev_r     = '0;
        forever begin
            @(negedge clk_i);
            #1;
            if (reset_i) begin
                prev_stall = 1'b0;
            end else begin
                if (ready_o && v_i) begin
                    exp_r = 1;
                    r_seq.delete();
                end
                chk("yumi", rk_yumi_o, rk_v_i && !rk_v_o);
                if (prev_stall && rk_v_o) begin
                    chk("stall_k", rk_k_o, prev_k);
                    chk("stall_r", rk_r_o, prev_r);
                end
                if (rk_v_o) begin
                    chk("req_r", rk_r_o, exp_r);
                    chk("req_k", rk_k_o, model_chunk(exp_r));
                    if (rk_ready_i) begin
                        r_seq.push_back(rk_r_o);
                        exp_r++;
                    end
                end
                prev_stall = rk_v_o && !rk_ready_i;
                prev_k     = rk_k_o;
                prev_r     = rk_r_o;
                if (done_o) begin
                    chk("done_iters", exp_r, 8);
                    valid_rk = pend_rk;
                end
                if (keys_valid_o) chk("rd_key", rd_key_o, exp_rd(rd_idx_i));
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic load_key(input logic [255:0] k);
        int n;
        n = 0;
        @(negedge clk_i);
        key_i = k;
        v_i   = 1'b1;
        while (!ready_o && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        chk("accept_ready", ready_o, 1'b1);
        model_expand(k);
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!done_o && n < 1000);
    endtask

    task automatic wait_issue(input int r);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(rk_v_o && rk_r_o == 4'(r)) && n < 200);
        chk("issue_seen", rk_r_o, r);
    endtask

    task automatic read_chk(input string name, input logic [3:0] idx, input logic [127:0] exp);
        rand_idx  = 1'b0;
        fixed_idx = idx;
        #1;
        chk(name, rd_key_o, exp);
        rand_idx  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int           n, extra;
        int           lat, st;
        logic [27:0]  seqv;
        logic [255:0] k;

        build_sbox();
        reset_i = 1'b1;
        flush_i = 1'b0;
        v_i     = 1'b0;
        key_i   = '0;
        #1;
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_rk_v", rk_v_o, 1'b0);
        chk("rst_yumi", rk_yumi_o, 1'b0);
        chk("rst_kv", keys_valid_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_rk_k", rk_k_o, '0);
        chk("rst_rk_r", rk_r_o, 4'd0);
        chk("rst_rd0", rd_key_o, '0);
        repeat (2) @(negedge clk_i);
        reset_i  = 1'b0;
        rand_idx = 1'b1;

        // FIPS-197 C.3 key, no backpressure, L=2
        resp_lat = 2; stall_n = 0;
        load_key(KEY_C3);
        wait_done(n);
        chk("c3_latency", n, 7*3 + 1);
        chk("c3_kv", keys_valid_o, 1'b1);
        read_chk("c3_idx0", 4'd0, 128'h000102030405060708090a0b0c0d0e0f);
        read_chk("c3_idx14", 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        extra = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (done_o) extra++;
        end
        chk("c3_done_once", extra, 0);
        chk("c3_kv_hold", keys_valid_o, 1'b1);

        // FIPS-197 A.3 key, L=1
        resp_lat = 1;
        load_key(KEY_A3);
        wait_done(n);
        chk("a3_latency", n, 7*2 + 1);
        read_chk("a3_idx2", 4'd2, 128'h9ba354118e6925afa51a8b5f2067fcde);
        read_chk("a3_idx14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        chk("a3_r_count", r_seq.size(), 7);
        seqv = '0;
        foreach (r_seq[i]) seqv = {seqv[23:0], r_seq[i]};
        chk("a3_r_seq", seqv, 28'h1234567);

        // Backpressure: 3 stall cycles in every ISSUE, 21 extra cycles
        stall_n = 3;
        load_key(KEY_A3);
        wait_done(n);
        chk("bp_latency", n, 7*2 + 1 + 21);
        read_chk("bp_idx2", 4'd2, 128'h9ba354118e6925afa51a8b5f2067fcde);
        read_chk("bp_idx14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        for (int i = 0; i < 15; i++) read_chk("bp_all", 4'(i), pend_rk[i]);
        stall_n = 0;

        // Busy: v_i during WAIT ignored, then reload straight from DONE
        resp_lat = 3;
        load_key(KEY_C3);
        wait_issue(1);
        @(negedge clk_i);
        key_i = rand_key();
        v_i   = 1'b1;
        chk("busy_ready", ready_o, 1'b0);
        @(negedge clk_i);
        v_i = 1'b0;
        wait_done(n);
        chk("busy_done", done_o, 1'b1);
        read_chk("busy_idx14", 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        load_key(rand_key());
        chk("reload_kv_drop", keys_valid_o, 1'b0);
        wait_done(n);
        chk("reload_latency", n, 7*4 + 1);
        read_chk("reload_idx5", 4'd5, pend_rk[5]);

        // Flush during iteration 4
        load_key(rand_key());
        wait_issue(4);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("flush_ready", ready_o, 1'b1);
        chk("flush_kv", keys_valid_o, 1'b0);
        chk("flush_rk_v", rk_v_o, 1'b0);
        n = 0;
        while (!rk_v_i && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("flush_late_v", rk_v_i, 1'b1);
        chk("flush_drain", rk_yumi_o, 1'b1);
        extra = 0;
        repeat (4) begin
            @(negedge clk_i);
            if (rk_v_o || done_o || keys_valid_o) extra++;
        end
        chk("flush_quiet", extra, 0);
        load_key(rand_key());
        wait_done(n);
        chk("flush_reload_latency", n, 7*4 + 1);
        read_chk("flush_idx7", 4'd7, pend_rk[7]);

        // Randomised schedules with random latency and backpressure
        for (int t = 0; t < 6; t++) begin
            lat = $urandom_range(1, 4);
            st  = $urandom_range(0, 2);
            resp_lat = lat;
            stall_n  = st;
            k = rand_key();
            load_key(k);
            wait_done(n);
            chk("rand_latency", n, 7*(lat + 1 + st) + 1);
            read_chk("rand_idx14", 4'd14, pend_rk[14]);
            repeat ($urandom_range(0, 4)) @(negedge clk_i);
        end
        stall_n = 0;

        // Asynchronous reset in the middle of WAIT
        resp_lat = 6;
        load_key(rand_key());
        wait_issue(1);
        @(negedge clk_i);
        @(negedge clk_i);
        rand_idx  = 1'b0;
        fixed_idx = 4'd15;
        #1;
        reset_i = 1'b1;
        #1;
        chk("arst_ready", ready_o, 1'b1);
        chk("arst_rk_v", rk_v_o, 1'b0);
        chk("arst_yumi", rk_yumi_o, 1'b0);
        chk("arst_kv", keys_valid_o, 1'b0);
        chk("arst_done", done_o, 1'b0);
        chk("arst_rk_k", rk_k_o, '0);
        chk("arst_rk_r", rk_r_o, 4'd0);
        chk("arst_rd15", rd_key_o, '0);
        fixed_idx = 4'd0;
        #1;
        chk("arst_rd0", rd_key_o, '0);
        repeat (2) @(negedge clk_i);
        reset_i  = 1'b0;
        rand_idx = 1'b1;
        resp_lat = 2;
        load_key(rand_key());
        wait_done(n);
        chk("post_rst_latency", n, 7*3 + 1);
        read_chk("post_rst_idx1", 4'd1, pend_rk[1]);

        repeat (3) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
